// File: rtl/aes_wb_initiator_if.sv
// Wishbone classic bus bundle between the AES sequencing initiator and the
// memory-mapped AES control responder.
interface aes_wb_initiator_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/aes_wb_initiator.sv
// Wishbone initiator running one AES-128 encryption on the AES control responder:
// core reset, key load, plaintext load, core release, status poll, ciphertext read.
module aes_wb_initiator #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned POLL_LIMIT  = 1024
) (
  input  logic               wb_clk_i,
  input  logic               wb_nrst_i,
  input  logic               start,
  input  logic [127:0]       key,
  input  logic [127:0]       plaintext,
  output logic [127:0]       ciphertext,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  aes_wb_initiator_if.master wbm
);

  localparam int unsigned WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [POLL_W-1:0] POLL_MAX  = POLL_W'(POLL_LIMIT);

  localparam logic [3:0] STEP_RELEASE = 4'd9;
  localparam logic [3:0] STEP_STATUS  = 4'd10;
  localparam logic [3:0] STEP_LAST    = 4'd14;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ACK  = 2'd1;
  localparam logic [1:0] ERR_POLL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  // Register offset of each step of the command sequence.
  function automatic logic [11:0] step_offset(input logic [3:0] step);
    logic [11:0] off;
    case (step)
      4'd0:    off = 12'h004;
      4'd1:    off = 12'h010;
      4'd2:    off = 12'h014;
      4'd3:    off = 12'h018;
      4'd4:    off = 12'h01C;
      4'd5:    off = 12'h020;
      4'd6:    off = 12'h024;
      4'd7:    off = 12'h028;
      4'd8:    off = 12'h02C;
      4'd9:    off = 12'h008;
      4'd10:   off = 12'h000;
      4'd11:   off = 12'h030;
      4'd12:   off = 12'h034;
      4'd13:   off = 12'h038;
      4'd14:   off = 12'h03C;
      default: off = 12'h000;
    endcase
    return off;
  endfunction

  function automatic logic [31:0] step_wdata(input logic [3:0]   step,
                                             input logic [127:0] k,
                                             input logic [127:0] p);
    logic [31:0] d;
    case (step)
      4'd1:    d = k[31:0];
      4'd2:    d = k[63:32];
      4'd3:    d = k[95:64];
      4'd4:    d = k[127:96];
      4'd5:    d = p[31:0];
      4'd6:    d = p[63:32];
      4'd7:    d = p[95:64];
      4'd8:    d = p[127:96];
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  state_e             state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [POLL_W-1:0]  poll_q, poll_d;
  logic [POLL_W-1:0]  poll_inc_s;
  logic               ready_q, ready_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       pt_q, pt_d;
  logic [127:0]       ct_q, ct_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic               load_s;
  logic               capture_s;

  assign poll_inc_s = poll_q + POLL_W'(1);

  // Sequencer next state; a start coinciding with the done pulse is dropped.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    wait_d     = wait_q;
    poll_d     = poll_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    load_s     = 1'b0;
    capture_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          state_d    = S_REQ;
          step_d     = 4'd0;
          wait_d     = '0;
          poll_d     = '0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          load_s     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (wbm.wbm_ack_i) begin
          state_d   = S_GAP;
          capture_s = 1'b1;
          if (step_q == STEP_STATUS) begin
            ready_d = wbm.wbm_dat_i[0];
          end else begin
            ready_d = ready_q;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          err_d      = 1'b1;
          err_code_d = ERR_ACK;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_GAP: begin
        // The responder still drives ack here, so this cycle never samples it.
        wait_d = '0;
        if (step_q == STEP_LAST) begin
          state_d = S_FIN;
        end else if (step_q == STEP_STATUS && !ready_q) begin
          if (poll_inc_s == POLL_MAX) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_POLL;
          end else begin
            poll_d  = poll_inc_s;
            state_d = S_REQ;
          end
        end else begin
          step_d  = step_q + 4'd1;
          state_d = S_REQ;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand latches and ciphertext word capture.
  always_comb begin
    key_d = load_s ? key : key_q;
    pt_d  = load_s ? plaintext : pt_q;
    ct_d  = ct_q;
    if (capture_s) begin
      case (step_q)
        4'd11:   ct_d[31:0]   = wbm.wbm_dat_i;
        4'd12:   ct_d[63:32]  = wbm.wbm_dat_i;
        4'd13:   ct_d[95:64]  = wbm.wbm_dat_i;
        4'd14:   ct_d[127:96] = wbm.wbm_dat_i;
        default: ct_d         = ct_q;
      endcase
    end else begin
      ct_d = ct_q;
    end
  end

  // Bus outputs decoded from the next state so the registers line up with REQ.
  always_comb begin
    cyc_d = (state_d == S_REQ);
    if (cyc_d) begin
      adr_d = BASE_ADDR + {20'h0_0000, step_offset(step_d)};
      we_d  = (step_d <= STEP_RELEASE);
      dat_d = step_wdata(step_d, key_d, pt_d);
    end else begin
      adr_d = 32'h0000_0000;
      we_d  = 1'b0;
      dat_d = 32'h0000_0000;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_nrst_i) begin
    if (!wb_nrst_i) begin
      state_q    <= S_IDLE;
      step_q     <= 4'd0;
      wait_q     <= '0;
      poll_q     <= '0;
      ready_q    <= 1'b0;
      key_q      <= 128'h0;
      pt_q       <= 128'h0;
      ct_q       <= 128'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 32'h0000_0000;
      dat_q      <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      wait_q     <= wait_d;
      poll_q     <= poll_d;
      ready_q    <= ready_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      ct_q       <= ct_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
    end
  end

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_sel_o = 4'hF;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;

  assign ciphertext = ct_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule
